// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (align, add, normalise) with valid/ready.
// Define FP_ADD_RNE_EN for round-to-nearest-even; the default build truncates.
module fp_add_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   parameter int unsigned TAG_W = 4,
   localparam int unsigned N = 1 + EXP_W + MAN_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [N-1:0]     i_operand1,
   input  logic [N-1:0]     i_operand2,
   input  logic             i_sub,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [N-1:0]     o_result,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_ovf,
   output logic             o_unf
);

   localparam int MW = MAN_W + 4;  // hidden + fraction + guard/round/sticky
   localparam int SW = MAN_W + 5;  // MW plus carry
   localparam int XW = EXP_W + 2;
   localparam int LZ_W = $clog2(MW);
   localparam logic signed [XW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

   logic adv;
   assign adv = ~o_valid | i_ready;
   assign o_ready = adv;

   // Align
   logic a_sign, b_sign, a_zero, b_zero, swap;
   logic [EXP_W-1:0] a_exp, b_exp, lg_exp, sm_exp, d;
   logic [MAN_W-1:0] a_frac, b_frac, lg_frac, sm_frac;
   logic lg_sign, lg_zero, sm_zero;
   logic [MW-1:0] lg_man, sm_man, sm_align;

   assign a_sign = i_operand1[N-1];
   assign b_sign = i_operand2[N-1] ^ i_sub;
   assign a_exp  = i_operand1[N-2 -: EXP_W];
   assign b_exp  = i_operand2[N-2 -: EXP_W];
   assign a_frac = i_operand1[MAN_W-1:0];
   assign b_frac = i_operand2[MAN_W-1:0];
   assign a_zero = (a_exp == '0);
   assign b_zero = (b_exp == '0);
   assign swap   = ~b_zero & (a_zero | ({b_exp, b_frac} > {a_exp, a_frac}));

   always_comb begin
      lg_sign  = swap ? b_sign : a_sign;
      lg_exp   = swap ? b_exp : a_exp;
      lg_frac  = swap ? b_frac : a_frac;
      lg_zero  = swap ? b_zero : a_zero;
      sm_exp   = swap ? a_exp : b_exp;
      sm_frac  = swap ? a_frac : b_frac;
      sm_zero  = swap ? a_zero : b_zero;
      lg_man   = lg_zero ? '0 : {1'b1, lg_frac, 3'b000};
      sm_man   = sm_zero ? '0 : {1'b1, sm_frac, 3'b000};
      d        = lg_exp - sm_exp;
      sm_align = '0;
      if (sm_zero) begin
         sm_align = '0;
      end else if (int'(d) >= MW) begin
         sm_align = {{(MW-1){1'b0}}, 1'b1};
      end else begin
         sm_align    = sm_man >> d;
         sm_align[0] = sm_align[0] | (|(sm_man & ~({MW{1'b1}} << d)));
      end
   end

   logic s1_valid, s1_sign, s1_eff_sub;
   logic [EXP_W-1:0] s1_exp;
   logic [MW-1:0] s1_lg, s1_sm;
   logic [TAG_W-1:0] s1_tag;

   // Add
   logic [SW-1:0] sum_d;
   assign sum_d = s1_eff_sub ? ({1'b0, s1_lg} - {1'b0, s1_sm}) : ({1'b0, s1_lg} + {1'b0, s1_sm});

   logic s2_valid, s2_sign;
   logic [EXP_W-1:0] s2_exp;
   logic [SW-1:0] s2_sum;
   logic [TAG_W-1:0] s2_tag;

   // Normalise: log-depth leading-zero shifter, widest shift first
   logic [LZ_W-1:0] lz;
   logic [MW-1:0] lz_man;

   for (genvar k = 0; k < LZ_W; k++) begin : g_lzc
      logic [MW-1:0] src, dst;
      logic zero_top;
      if (k == LZ_W - 1) begin : g_first
         assign src = s2_sum[MW-1:0];
      end else begin : g_next
         assign src = g_lzc[k+1].dst;
      end
      assign zero_top = ~|src[MW-1 -: (1 << k)];
      assign dst = zero_top ? (src << (1 << k)) : src;
      assign lz[k] = zero_top;
   end
   assign lz_man = g_lzc[0].dst;

   logic carry;
   logic [MW-1:0] norm;
   logic signed [XW-1:0] exp_base, exp_n, exp_r;
   logic [MAN_W-1:0] frac_r;

   assign carry    = s2_sum[SW-1];
   assign norm     = carry ? {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]} : lz_man;
   assign exp_base = $signed({2'b00, s2_exp});
   assign exp_n    = carry ? exp_base + XW'(1) : exp_base - XW'(lz);

`ifdef FP_ADD_RNE_EN
   logic round_up;
   logic [MAN_W+1:0] rnd;
   always_comb begin
      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      rnd      = {1'b0, norm[MW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
      if (rnd[MAN_W+1]) begin
         frac_r = rnd[MAN_W:1];
         exp_r  = exp_n + XW'(1);
      end else begin
         frac_r = rnd[MAN_W-1:0];
         exp_r  = exp_n;
      end
   end
`else
   logic unused_grs;
   assign unused_grs = ^{norm[MW-1], norm[2:0]};
   assign frac_r = norm[MW-2:3];
   assign exp_r  = exp_n;
`endif

   logic [N-1:0] res_d;
   logic ovf_d, unf_d;

   always_comb begin
      res_d = {s2_sign, exp_r[EXP_W-1:0], frac_r};
      ovf_d = 1'b0;
      unf_d = 1'b0;
      if (s2_sum == '0) begin
         res_d = '0;
      end else if (exp_r >= EXP_MAX) begin
         res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         ovf_d = 1'b1;
      end else if (exp_r[XW-1] || exp_r == '0) begin
         res_d = {s2_sign, {(N-1){1'b0}}};
         unf_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1_valid   <= 1'b0;
         s1_sign    <= 1'b0;
         s1_eff_sub <= 1'b0;
         s1_exp     <= '0;
         s1_lg      <= '0;
         s1_sm      <= '0;
         s1_tag     <= '0;
         s2_valid   <= 1'b0;
         s2_sign    <= 1'b0;
         s2_exp     <= '0;
         s2_sum     <= '0;
         s2_tag     <= '0;
         o_valid    <= 1'b0;
         o_result   <= '0;
         o_tag      <= '0;
         o_ovf      <= 1'b0;
         o_unf      <= 1'b0;
      end else if (adv) begin
         s1_valid   <= i_valid;
         s1_sign    <= lg_sign;
         s1_eff_sub <= a_sign ^ b_sign;
         s1_exp     <= lg_exp;
         s1_lg      <= lg_man;
         s1_sm      <= sm_align;
         s1_tag     <= i_tag;
         s2_valid   <= s1_valid;
         s2_sign    <= s1_sign;
         s2_exp     <= s1_exp;
         s2_sum     <= sum_d;
         s2_tag     <= s1_tag;
         o_valid    <= s2_valid;
         o_result   <= res_d;
         o_tag      <= s2_tag;
         o_ovf      <= s2_valid & ovf_d;
         o_unf      <= s2_valid & unf_d;
      end
   end

endmodule
